// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round count and message-schedule sigma functions.
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package sha256_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:15] block_t;

  localparam int SHA256_ROUNDS = 64;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } sched_state_e;

  // Rotate right by a constant amount; callers always pass literals.
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Next schedule word from the sliding window taps W[t-16], W[t-15], W[t-7], W[t-2].
// Latency: purely combinational.
// Backpressure: none; the caller decides when to latch the result.
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w0_i,
  input  logic [31:0] w1_i,
  input  logic [31:0] w9_i,
  input  logic [31:0] w14_i,
  output logic [31:0] w15_next_o
);

  // Additions wrap modulo 2^32 by the 32-bit result width.
  assign w15_next_o = sigma1(w14_i) + w9_i + sigma0(w1_i) + w0_i;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: accepts a 512-bit block, streams W0..W63 one word per cycle.
// Latency: W0 valid one cycle after block acceptance; back-to-back blocks with no bubble.
// Backpressure: w_ready low freezes window, index and outputs; blk_ready only at the W63 handshake.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             blk_valid,
  input  logic [0:15][31:0] blk_data,
  output logic             blk_ready,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [31:0]      w_data,
  output logic [5:0]       w_idx,
  output logic             w_last,
  output logic             busy
);

  localparam logic [5:0] LAST_IDX = 6'(SHA256_ROUNDS - 1);

  sched_state_e state_q, state_d;
  block_t       win_q, win_d;
  logic [5:0]   idx_q, idx_d;
  word_t        w15_next;
  logic         at_last;
  logic         blk_hs;
  logic         w_hs;

  sha256_w_expand u_expand (
    .w0_i       (win_q[0]),
    .w1_i       (win_q[1]),
    .w9_i       (win_q[9]),
    .w14_i      (win_q[14]),
    .w15_next_o (w15_next)
  );

  assign at_last   = (idx_q == LAST_IDX);
  assign w_valid   = (state_q == ST_STREAM);
  assign busy      = w_valid;
  assign blk_ready = (state_q == ST_IDLE) || (at_last && w_ready);
  assign w_data    = win_q[0];
  assign w_idx     = idx_q;
  assign w_last    = w_valid && at_last;
  assign blk_hs    = blk_valid && blk_ready;
  assign w_hs      = w_valid && w_ready;

  // Next state: a block reload wins over the final-word shift so chained blocks see no bubble.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    idx_d   = idx_q;
    if (blk_hs) begin
      win_d   = blk_data;
      idx_d   = '0;
      state_d = ST_STREAM;
    end else if (w_hs) begin
      win_d = {win_q[1:15], w15_next};
      if (at_last) begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end else begin
        idx_d = idx_q + 6'd1;
      end
    end
  end

  // State, window and index registers; reset drops any in-flight block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
    end
  end

endmodule
